// File: rtl/cosine_pkg.sv
// Shared Q5.11 constants and FSM state encoding for the cosine argument path.
// Combinational helpers only; no state lives here.
// The constants are rounded to nearest and hold only for FRAC = 11.
package cosine_pkg;

  localparam int W    = 16;
  localparam int FRAC = 11;
  localparam int AW   = W + 1;  // accumulator width, so |-16.0| is exact

  localparam logic [AW-1:0] TWO_PI  = 17'd12868;  // 0x3244
  localparam logic [AW-1:0] PI      = 17'd6434;   // 0x1922
  localparam logic [AW-1:0] HALF_PI = 17'd3217;   // 0x0C91

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ABS  = 3'd1;
  localparam logic [2:0] S_WRAP = 3'd2;
  localparam logic [2:0] S_HALF = 3'd3;
  localparam logic [2:0] S_QUAD = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Magnitude of a signed W-bit word. The result is one bit wider so that
  // the most negative input maps to +2^(W-1) without overflow.
  function automatic logic [AW-1:0] abs_q(input logic [W-1:0] x);
    logic [AW-1:0] s;
    s = {x[W-1], x};
    return x[W-1] ? (~s + 17'd1) : s;
  endfunction

endpackage

// File: rtl/fx_cond_sub.sv
// Conditional subtract: o_y = (i_a >= i_c) ? i_a - i_c : i_a.
// Purely combinational; o_taken reports whether the subtraction happened.
// Operands are unsigned, so the subtraction can never underflow when taken.
module fx_cond_sub
  import cosine_pkg::*;
(
  input  logic [AW-1:0] i_a,
  input  logic [AW-1:0] i_c,
  output logic [AW-1:0] o_y,
  output logic          o_taken
);

  logic          w_ge;
  logic [AW-1:0] w_diff;

  assign w_ge    = (i_a >= i_c);
  assign w_diff  = i_a - i_c;
  assign o_y     = w_ge ? w_diff : i_a;
  assign o_taken = w_ge;

endmodule

// File: rtl/cos_range_reducer.sv
// Reduces a signed Q5.11 angle to r in [0, pi/2] plus a negate flag for cosine.
// Latency: done pulses 4..6 edges after the accepting edge (4 + number of 2*pi wraps).
// No queueing: start is sampled only while idle; requests arriving while busy are dropped.
module cos_range_reducer
  import cosine_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  x_in,
  output logic [W-1:0]  x_out,
  output logic          neg,
  output logic          busy,
  output logic          done
);

  logic [2:0]    r_state;
  logic [W-1:0]  r_x;
  logic [AW-1:0] r_a;
  logic          r_flip;
  logic [W-1:0]  r_xout;
  logic          r_neg;
  logic          r_busy;
  logic          r_done;

  logic [AW-1:0] w_sub_c;
  logic [AW-1:0] w_sub_y;
  logic          w_sub_taken;
  logic [AW-1:0] w_fold;
  logic          w_fold_take;
  logic [AW-1:0] w_quad_a;
  logic          w_quad_flip;

  // One shared conditional subtractor: 2*pi while wrapping, pi in the half step.
  assign w_sub_c = (r_state == S_HALF) ? PI : TWO_PI;

  fx_cond_sub u_cond_sub (
    .i_a     (r_a),
    .i_c     (w_sub_c),
    .o_y     (w_sub_y),
    .o_taken (w_sub_taken)
  );

  // Quadrant fold: cos(a) = -cos(pi - a). Only reached with a < pi, so no underflow.
  assign w_fold      = PI - r_a;
  assign w_fold_take = (r_a > HALF_PI);
  assign w_quad_a    = w_fold_take ? w_fold : r_a;
  assign w_quad_flip = r_flip ^ w_fold_take;

  assign x_out = r_xout;
  assign neg   = r_neg;
  assign busy  = r_busy;
  assign done  = r_done;

  // Sequencer: one reduction step per edge; results are published on entry to DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_a     <= '0;
      r_flip  <= 1'b0;
      r_xout  <= '0;
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x     <= x_in;
            r_busy  <= 1'b1;
            r_state <= S_ABS;
          end
        end
        S_ABS: begin
          r_a     <= abs_q(r_x);
          r_flip  <= 1'b0;
          r_state <= S_WRAP;
        end
        S_WRAP: begin
          if (w_sub_taken) begin
            r_a <= w_sub_y;
          end else begin
            r_state <= S_HALF;
          end
        end
        S_HALF: begin
          r_a     <= w_sub_y;
          r_flip  <= r_flip ^ w_sub_taken;
          r_state <= S_QUAD;
        end
        S_QUAD: begin
          r_a     <= w_quad_a;
          r_flip  <= w_quad_flip;
          r_xout  <= w_quad_a[W-1:0];
          r_neg   <= w_quad_flip;
          r_done  <= 1'b1;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cos_range_reducer.sv
// Scoreboard bench for cos_range_reducer: directed vectors plus a few random angles.
// Stimulus pushes expectations; a negedge monitor pops and compares on every done.
// Latency is measured from the accepting edge to the edge that raises done.
module tb_cos_range_reducer;

  typedef struct {
    logic [15:0] x;
    logic [15:0] ex;
    logic        en;
    bit          exact;
    int          lat;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] x_out;
  logic        neg;
  logic        busy;
  logic        done;

  int   checks;
  int   errors;
  int   cyc;
  int   n_done;
  exp_t sb[$];
  exp_t e;

  cos_range_reducer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .x_in  (x_in),
    .x_out (x_out),
    .neg   (neg),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst && done) begin
      n_done++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done x_out=0x%0h neg=%0b", x_out, neg);
      end else begin
        real xo, got, want, err;
        e = sb.pop_front();
        if (e.exact) begin
          chk($sformatf("x_out[x=%h]", e.x), int'(x_out), int'(e.ex));
          chk($sformatf("neg[x=%h]", e.x), int'(neg), int'(e.en));
        end else begin
          xo   = $itor(x_out) / 2048.0;
          got  = neg ? -$cos(xo) : $cos(xo);
          want = $cos($itor($signed(e.x)) / 2048.0);
          err  = (got > want) ? got - want : want - got;
          checks++;
          if (err >= 1.0 / 1024.0) begin
            errors++;
            $display("FAIL cos_err[x=%h] x_out=0x%0h neg=%0b err=%f limit=%f",
                     e.x, x_out, neg, err, 1.0 / 1024.0);
          end
          chk($sformatf("range[x=%h]", e.x), int'(x_out <= 16'h0C91), 1);
        end
        if (e.lat >= 0)
          chk($sformatf("latency[x=%h]", e.x), cyc - e.acc, e.lat);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] x, input logic [15:0] ex, input logic en,
                      input bit exact, input int lat, input int acc);
    exp_t t;
    t.x = x; t.ex = ex; t.en = en; t.exact = exact; t.lat = lat; t.acc = acc;
    sb.push_back(t);
  endtask

  // Drive one start pulse; the accepting edge is the next rising edge.
  task automatic issue(input logic [15:0] x, input logic [15:0] ex, input logic en,
                       input bit exact, input int lat);
    push(x, ex, en, exact, lat, cyc + 1);
    start = 1'b1;
    x_in  = x;
    step();
    start = 1'b0;
    chk("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 30 && n_done < target; i++) step();
    if (n_done < target) begin
      checks++;
      errors++;
      $display("FAIL done_timeout seen=%0d want=%0d", n_done, target);
      sb.delete();
    end
  endtask

  // Full job: issue, wait for done, then confirm the pulse is single-cycle and busy drops.
  task automatic run_job(input logic [15:0] x, input logic [15:0] ex, input logic en,
                         input bit exact, input int lat);
    int target;
    target = n_done + 1;
    issue(x, ex, en, exact, lat);
    wait_done(target);
    step();
    chk("done_one_cycle", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int target;
    logic [31:0] r32;
    checks = 0; errors = 0; cyc = 0; n_done = 0;
    rst = 1'b0; start = 1'b0; x_in = '0;
    repeat (3) step();
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_neg", int'(neg), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b1;
    step();

    // Directed vectors: x, expected r, expected neg, latency.
    run_job(16'h0400, 16'h0400, 1'b0, 1, 4);
    run_job(16'h1922, 16'h0000, 1'b1, 1, 4);
    run_job(16'h0F49, 16'h09D9, 1'b1, 1, 4);
    run_job(16'h3800, 16'h05BC, 1'b0, 1, 5);
    run_job(16'h8000, 16'h0256, 1'b1, 1, 6);
    run_job(16'h3244, 16'h0000, 1'b0, 1, 5);
    run_job(16'hFC00, 16'h0400, 1'b0, 1, 4);
    run_job(16'h0C91, 16'h0C91, 1'b0, 1, 4);
    repeat (3) step();
    chk("x_out_hold", int'(x_out), 16'h0C91);

    // start pulsed while wrapping must be ignored.
    target = n_done + 1;
    issue(16'h8000, 16'h0256, 1'b1, 1, 6);
    step();
    start = 1'b1;
    x_in  = 16'h0400;
    step();
    start = 1'b0;
    wait_done(target);
    repeat (8) step();

    // start held through DONE: a second job is accepted after one idle cycle.
    target = n_done + 1;
    push(16'h3800, 16'h05BC, 1'b0, 1, 5, cyc + 1);
    push(16'h0400, 16'h0400, 1'b0, 1, -1, 0);
    start = 1'b1;
    x_in  = 16'h3800;
    step();
    x_in  = 16'h0400;
    wait_done(target);
    step();
    step();
    start = 1'b0;
    chk("busy_second_job", int'(busy), 1);
    wait_done(target + 1);
    repeat (3) step();

    // Reset asserted while in HALF: outputs clear and no done is produced.
    issue(16'h0400, 16'h0400, 1'b0, 1, 4);
    void'(sb.pop_back());
    step();
    step();
    rst = 1'b0;
    step();
    chk("midrst_x_out", int'(x_out), 0);
    chk("midrst_neg", int'(neg), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    rst = 1'b1;
    repeat (8) step();
    run_job(16'h0F49, 16'h09D9, 1'b1, 1, 4);

    // Random angles checked against real cosine.
    for (int i = 0; i < 10; i++) begin
      r32 = $urandom();
      run_job(r32[15:0], 16'h0000, 1'b0, 0, -1);
    end
    repeat (4) step();
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
